// File: rtl/mem_bus_pkg.sv
// Shared encodings and constants for the CPU memory bus responder.
package mem_bus_pkg;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  // What o_rdata shows between responses.
  typedef enum logic [1:0] {SEL_ZERO, SEL_RAM, SEL_ERR} rsel_e;

  localparam logic [31:0] RESET_VECTOR = 32'hb0000000;
  localparam logic [31:0] ERR_DATA     = 32'hdeadbeef;
  localparam logic [3:0]  BE_WORD      = 4'b1111;
  localparam logic [3:0]  BE_BYTE0     = 4'b0001;

endpackage

// File: rtl/mem_responder_if.sv
// Request/response signals between the CPU (master) and the memory responder (slave).
interface mem_responder_if;
  logic        i_req;
  logic        i_we;
  logic [31:0] i_addr;
  logic [31:0] i_wdata;
  logic [3:0]  i_be;
  logic [31:0] o_rdata;
  logic        o_ack;
  logic        o_err;
  logic        o_busy;

  modport master (output i_req, i_we, i_addr, i_wdata, i_be,
                  input  o_rdata, o_ack, o_err, o_busy);
  modport slave  (input  i_req, i_we, i_addr, i_wdata, i_be,
                  output o_rdata, o_ack, o_err, o_busy);
endinterface

// File: rtl/mem_responder_ram_sp_be.sv
// Single-port synchronous RAM, 32-bit words, per-byte write enables.
module ram_sp_be #(
  parameter int    ADDR_WIDTH = 10,
  parameter string INIT_FILE  = ""
) (
  input  logic                  clk,
  input  logic                  en_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [31:0]           wdata_i,
  input  logic [3:0]            be_i,
  output logic [31:0]           rdata_o
);
  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [31:0] mem_q [DEPTH];
  logic [31:0] rdata_q;

  initial begin
    for (int i = 0; i < DEPTH; i++) mem_q[i] = '0;
  end

  // Read data register only updates on reads, so it holds across writes/idle.
  always_ff @(posedge clk) begin
    if (en_i) begin
      if (we_i) begin
        for (int b = 0; b < 4; b++)
          if (be_i[b]) mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end else begin
        rdata_q <= mem_q[addr_i];
      end
    end
  end

  assign rdata_o = rdata_q;
endmodule

// File: rtl/mem_responder.sv
// Boot/program memory responder: on-chip RAM window with wait states and error responses.
module mem_responder
  import mem_bus_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'hb0000000,
  parameter int          ADDR_WIDTH  = 10,
  parameter int          WAIT_STATES = 1,
  parameter string       INIT_FILE   = ""
) (
  input  logic            clk,
  input  logic            reset,
  mem_responder_if.slave  bus
);
  localparam int            TAG_LSB = ADDR_WIDTH + 2;
  localparam logic [3:0]    WS_LOAD = 4'(WAIT_STATES - 1);

  state_e                state_q, state_d;
  rsel_e                 sel_q, sel_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  we_q, we_d, hit_q, hit_d;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [3:0]            be_q, be_d;
  logic                  ack_q, ack_d, err_q, err_d, busy_q, busy_d;
  logic                  go_resp;

  logic                  idle, in_hit;
  logic                  r_we, r_hit;
  logic [ADDR_WIDTH-1:0] r_idx;
  logic [31:0]           r_wdata, ram_rdata;
  logic [3:0]            r_be;

  assign idle   = (state_q == IDLE);
  assign in_hit = (bus.i_addr[31:TAG_LSB] == BASE_ADDR[31:TAG_LSB]) && (bus.i_addr[1:0] == 2'b00);

  // With zero wait states the response is issued on the acceptance edge,
  // so the RAM must see the live request rather than the latched copy.
  assign r_we    = idle ? bus.i_we                : we_q;
  assign r_hit   = idle ? in_hit                  : hit_q;
  assign r_idx   = idle ? bus.i_addr[TAG_LSB-1:2] : idx_q;
  assign r_wdata = idle ? bus.i_wdata             : wdata_q;
  assign r_be    = idle ? bus.i_be                : be_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    hit_d   = hit_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    sel_d   = sel_q;
    busy_d  = busy_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    go_resp = 1'b0;
    case (state_q)
      IDLE: if (bus.i_req) begin
        we_d    = bus.i_we;
        hit_d   = in_hit;
        idx_d   = bus.i_addr[TAG_LSB-1:2];
        wdata_d = bus.i_wdata;
        be_d    = bus.i_be;
        busy_d  = 1'b1;
        if (WAIT_STATES == 0) begin
          go_resp = 1'b1;
        end else begin
          cnt_d   = WS_LOAD;
          state_d = WAIT;
        end
      end
      WAIT: if (cnt_q == 4'd0) go_resp = 1'b1;
            else               cnt_d   = cnt_q - 4'd1;
      RESP: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase
    if (go_resp) begin
      state_d = RESP;
      busy_d  = 1'b1;
      ack_d   = r_hit;
      err_d   = !r_hit;
      sel_d   = !r_hit ? SEL_ERR : (r_we ? SEL_ZERO : SEL_RAM);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      hit_q   <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      sel_q   <= SEL_ZERO;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      hit_q   <= hit_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      sel_q   <= sel_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
    end
  end

  // Gating with reset makes reset win over a write landing on the same edge.
  ram_sp_be #(.ADDR_WIDTH(ADDR_WIDTH), .INIT_FILE(INIT_FILE)) u_ram (
    .clk    (clk),
    .en_i   (go_resp && r_hit && reset),
    .we_i   (r_we),
    .addr_i (r_idx),
    .wdata_i(r_wdata),
    .be_i   (r_be),
    .rdata_o(ram_rdata)
  );

  assign bus.o_rdata = (sel_q == SEL_RAM) ? ram_rdata :
                       (sel_q == SEL_ERR) ? ERR_DATA  : 32'h0;
  assign bus.o_ack   = ack_q;
  assign bus.o_err   = err_q;
  assign bus.o_busy  = busy_q;
endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder across WAIT_STATES 0..3 (instance index == wait states).
module tb_mem_responder;
  import mem_bus_pkg::*;

  logic        clk = 1'b0, reset = 1'b0;
  logic        req = 1'b0, we = 1'b0;
  logic [31:0] addr = '0, wdata = '0;
  logic [3:0]  be = '0;
  int          sel = 1;
  logic        ack, err, busy;
  logic [31:0] rdata;
  int          checks = 0, errors = 0;

  typedef struct { logic err; logic [31:0] rdata; } exp_t;
  exp_t        sb[$];
  logic [31:0] model [4][1024];

  always #5 clk = ~clk;

  mem_responder_if bus0(), bus1(), bus2(), bus3();

  assign bus0.i_req = req && (sel == 0); assign bus0.i_we = we; assign bus0.i_addr = addr;
  assign bus0.i_wdata = wdata; assign bus0.i_be = be;
  assign bus1.i_req = req && (sel == 1); assign bus1.i_we = we; assign bus1.i_addr = addr;
  assign bus1.i_wdata = wdata; assign bus1.i_be = be;
  assign bus2.i_req = req && (sel == 2); assign bus2.i_we = we; assign bus2.i_addr = addr;
  assign bus2.i_wdata = wdata; assign bus2.i_be = be;
  assign bus3.i_req = req && (sel == 3); assign bus3.i_we = we; assign bus3.i_addr = addr;
  assign bus3.i_wdata = wdata; assign bus3.i_be = be;

  mem_responder #(.WAIT_STATES(0)) u0 (.clk(clk), .reset(reset), .bus(bus0.slave));
  mem_responder #(.WAIT_STATES(1)) u1 (.clk(clk), .reset(reset), .bus(bus1.slave));
  mem_responder #(.WAIT_STATES(2)) u2 (.clk(clk), .reset(reset), .bus(bus2.slave));
  mem_responder #(.WAIT_STATES(3)) u3 (.clk(clk), .reset(reset), .bus(bus3.slave));

  always_comb begin
    case (sel)
      0:       begin ack = bus0.o_ack; err = bus0.o_err; busy = bus0.o_busy; rdata = bus0.o_rdata; end
      2:       begin ack = bus2.o_ack; err = bus2.o_err; busy = bus2.o_busy; rdata = bus2.o_rdata; end
      3:       begin ack = bus3.o_ack; err = bus3.o_err; busy = bus3.o_busy; rdata = bus3.o_rdata; end
      default: begin ack = bus1.o_ack; err = bus1.o_err; busy = bus1.o_busy; rdata = bus1.o_rdata; end
    endcase
  end

  function automatic bit in_win(input logic [31:0] a);
    return (a >= 32'hb0000000) && (a <= 32'hb0000ffc) && (a % 4 == 0);
  endfunction

  // One access on instance `sel`; expected result queued up front, checked on the response.
  task automatic access(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] b, input bit hold, output logic [31:0] got);
    exp_t e;
    int   idx, lat;
    bit   done;
    idx     = int'((a - 32'hb0000000) >> 2) % 1024;
    e.err   = !in_win(a);
    e.rdata = 32'hdeadbeef;
    if (!e.err) begin
      if (w) begin
        e.rdata = 32'h0;
        for (int k = 0; k < 4; k++)
          if (b[k]) model[sel][idx][8*k +: 8] = d[8*k +: 8];
      end else begin
        e.rdata = model[sel][idx];
      end
    end
    sb.push_back(e);
    got = 'x;
    @(negedge clk); req = 1'b1; we = w; addr = a; wdata = d; be = b;
    @(posedge clk);
    lat = 0; done = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      if (c == 0 && !hold) req = 1'b0;
      checks++;
      if (busy !== 1'b1) begin errors++; $display("FAIL busy_during a=%h c=%0d got %b want 1", a, c, busy); end
      if (ack === 1'b1 || err === 1'b1) begin
        done = 1'b1;
        e = sb.pop_front();
        checks++;
        if (lat != sel) begin errors++; $display("FAIL latency a=%h ws=%0d got %0d want %0d", a, sel, lat, sel); end
        checks++;
        if (ack !== !e.err || err !== e.err)
          begin errors++; $display("FAIL resp_kind a=%h got ack=%b err=%b want err=%b", a, ack, err, e.err); end
        checks++;
        if (rdata !== e.rdata) begin errors++; $display("FAIL rdata a=%h got %h want %h", a, rdata, e.rdata); end
        got = rdata;
        req = 1'b0;
      end else begin
        lat++;
      end
    end
    checks++;
    if (!done) begin errors++; $display("FAIL timeout a=%h got no response want ack/err", a); end
    @(negedge clk);
    checks++;
    if (ack !== 1'b0 || err !== 1'b0 || busy !== 1'b0 || rdata !== e.rdata)
      begin errors++; $display("FAIL after_resp a=%h got ack=%b err=%b busy=%b rdata=%h want 0 0 0 %h",
                                a, ack, err, busy, rdata, e.rdata); end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int s = 0; s < 4; s++) begin
      sel = s; #0;
      checks++;
      if (ack !== 1'b0 || err !== 1'b0 || busy !== 1'b0 || rdata !== 32'h0)
        begin errors++; $display("FAIL reset_state ws=%0d got ack=%b err=%b busy=%b rdata=%h want all 0", s, ack, err, busy, rdata); end
    end
    reset = 1'b1;
    sel = 1;
  endtask

  task automatic test_read_latency();
    logic [31:0] got;
    sel = 1;
    access(1'b1, RESET_VECTOR, 32'h1000abcd, BE_WORD, 1'b1, got);
    access(1'b0, RESET_VECTOR, 32'h0, BE_WORD, 1'b1, got);
    checks++;
    if (got !== 32'h1000abcd) begin errors++; $display("FAIL reset_vector_read got %h want 1000abcd", got); end
  endtask

  task automatic test_byte_enables();
    logic [31:0] got;
    sel = 1;
    access(1'b1, 32'hb0000010, 32'h11223344, BE_WORD, 1'b1, got);
    access(1'b1, 32'hb0000010, 32'haabbccdd, 4'b0010, 1'b1, got);
    access(1'b0, 32'hb0000010, 32'h0, BE_WORD, 1'b1, got);
    checks++;
    if (got !== 32'h1122cc44) begin errors++; $display("FAIL byte_merge got %h want 1122cc44", got); end
    access(1'b1, 32'hb0000010, 32'hffffffff, 4'b0000, 1'b1, got);
    access(1'b1, 32'hb0000014, 32'h00000077, BE_BYTE0, 1'b1, got);
    access(1'b0, 32'hb0000010, 32'h0, BE_WORD, 1'b1, got);
    access(1'b0, 32'hb0000014, 32'h0, BE_WORD, 1'b1, got);
  endtask

  task automatic test_errors();
    logic [31:0] got;
    sel = 1;
    access(1'b0, 32'hb0001000, 32'h0, BE_WORD, 1'b1, got);
    access(1'b0, 32'hb0000002, 32'h0, BE_WORD, 1'b1, got);
    access(1'b1, 32'hb0000012, 32'h99999999, BE_WORD, 1'b1, got);
    access(1'b1, 32'hb0001000, 32'h99999999, BE_WORD, 1'b1, got);
    access(1'b0, 32'haffffffc, 32'h0, BE_WORD, 1'b1, got);
    access(1'b1, 32'hb0000ffc, 32'hcafef00d, BE_WORD, 1'b1, got);
    access(1'b0, 32'hb0000ffc, 32'h0, BE_WORD, 1'b1, got);
    access(1'b0, 32'hb0000010, 32'h0, BE_WORD, 1'b1, got);
    access(1'b0, 32'hb0000000, 32'h0, BE_WORD, 1'b1, got);
  endtask

  task automatic test_back_to_back();
    logic [31:0] got;
    exp_t e;
    int   n, last;
    sel = 0;
    for (int i = 0; i < 3; i++)
      access(1'b1, 32'hb0000000 + 32'(4*i), 32'hc0de0000 + 32'(i), BE_WORD, 1'b1, got);
    for (int i = 0; i < 3; i++) begin
      e.err = 1'b0; e.rdata = 32'hc0de0000 + 32'(i); sb.push_back(e);
    end
    @(negedge clk); req = 1'b1; we = 1'b0; addr = 32'hb0000000; be = BE_WORD;
    n = 0; last = -1;
    for (int c = 0; c < 30 && n < 3; c++) begin
      @(negedge clk);
      if (ack === 1'b1 || err === 1'b1) begin
        e = sb.pop_front();
        checks++;
        if (ack !== 1'b1 || rdata !== e.rdata)
          begin errors++; $display("FAIL b2b_data n=%0d got ack=%b rdata=%h want 1 %h", n, ack, rdata, e.rdata); end
        if (n > 0) begin
          checks++;
          if (c - last != 2) begin errors++; $display("FAIL b2b_spacing n=%0d got %0d want 2", n, c - last); end
        end
        last = c; n++;
        if (n < 3) addr = 32'hb0000000 + 32'(4*n);
        else       req = 1'b0;
      end
    end
    checks++;
    if (n != 3) begin errors++; $display("FAIL b2b_count got %0d want 3", n); end
    req = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++;
      if (ack !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL b2b_extra c=%0d got ack=%b err=%b want 0 0", c, ack, err); end
    end
  endtask

  // Start a write, then pull reset `rst_after` negedges after acceptance.
  task automatic aborted_write(input int s, input logic [31:0] a, input logic [31:0] d, input int rst_after);
    logic [31:0] got;
    sel = s;
    @(negedge clk); req = 1'b1; we = 1'b1; addr = a; wdata = d; be = BE_WORD;
    @(posedge clk);
    @(negedge clk); req = 1'b0;
    for (int i = 0; i < rst_after; i++) @(negedge clk);
    reset = 1'b0;
    @(negedge clk); reset = 1'b1;
    for (int c = 0; c < 6; c++) begin
      checks++;
      if (ack !== 1'b0 || err !== 1'b0 || busy !== 1'b0)
        begin errors++; $display("FAIL abort_quiet ws=%0d c=%0d got ack=%b err=%b busy=%b want 0 0 0", s, c, ack, err, busy); end
      @(negedge clk);
    end
    access(1'b0, a, 32'h0, BE_WORD, 1'b1, got);
    checks++;
    if (got !== 32'h0) begin errors++; $display("FAIL abort_nowrite ws=%0d got %h want 00000000", s, got); end
  endtask

  task automatic test_reset_abort();
    aborted_write(3, 32'hb0000020, 32'h00000055, 0);
    aborted_write(1, 32'hb0000030, 32'h00000077, 0);
  endtask

  task automatic test_pulsed_req();
    logic [31:0] got;
    sel = 2;
    access(1'b1, 32'hb0000004, 32'h5a5a1234, BE_WORD, 1'b1, got);
    access(1'b0, 32'hb0000004, 32'h0, BE_WORD, 1'b0, got);
    checks++;
    if (got !== 32'h5a5a1234) begin errors++; $display("FAIL pulsed_read got %h want 5a5a1234", got); end
  endtask

  initial begin
    for (int s = 0; s < 4; s++)
      for (int i = 0; i < 1024; i++) model[s][i] = 32'h0;
    test_reset();
    test_read_latency();
    test_byte_enables();
    test_errors();
    test_back_to_back();
    test_reset_abort();
    test_pulsed_req();
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL scoreboard_left got %0d want 0", sb.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  always @(negedge clk) begin
    if (reset && ack === 1'b1 && err === 1'b1) begin
      checks++; errors++;
      $display("FAIL ack_err_both ws=%0d got 1 1 want exclusive", sel);
    end
  end
endmodule
